// File: rtl/dataTypes_pkg.sv
// Shared types and field positions for the CAN frame assembler.
package dataTypes_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_FILL,
    ST_CAPTURE,
    ST_ADVANCE,
    ST_SETTLE,
    ST_PRESENT,
    ST_DONE,
    ST_ERROR
  } chfaState_t;

  // Bit positions inside the first two words of each frame.
  localparam int CHFA_ID_MSB  = 28;
  localparam int CHFA_IDE_BIT = 29;
  localparam int CHFA_RTR_BIT = 30;
  localparam int CHFA_DLC_MSB = 3;

  localparam int CHFA_WORDS_PER_FRAME = 4;

endpackage

// File: rtl/chfa_timeout_counter.sv
// Fill-wait timeout counter: cleared on request, counts while enabled and
// flags the terminal count once TIMEOUT_CYCLES waiting cycles have elapsed.
module chfa_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Counter clears on request and saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/can_frame_assembler.sv
// CAN frame assembler: drains the BRAM read controller word buffer and packs
// every four 32-bit words into one CAN frame descriptor for the transmitter.
// Optional build macro CHFA_DLC_CLAMP_EN: clamps dlc to 8 and zeroes data
// bytes beyond the clamped length.
module can_frame_assembler
  import dataTypes_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic [15:0] baseAddr,
  input  logic [13:0] numFrames,
  output logic [15:0] requestAddr,
  output logic [15:0] numReads,
  output logic        clear,
  output logic        advanceBuffer,
  input  logic [31:0] requestData,
  input  logic        dataValid,
  output logic [28:0] frameId,
  output logic        frameIde,
  output logic        frameRtr,
  output logic [3:0]  frameDlc,
  output logic [63:0] frameData,
  output logic        frameValid,
  input  logic        frameReady,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_WORD   = 2'(CHFA_WORDS_PER_FRAME - 1);

  chfaState_t  state, state_next;
  logic [1:0]  word_idx;
  logic [7:0]  settle_cnt;
  logic [13:0] frame_cnt;
  logic [13:0] num_frames_q;
  logic        accept;
  logic        to_tc;

  logic        clear_next, adv_next, valid_next, busy_next, done_next, error_next;

  logic [3:0]  cap_dlc;
  logic [31:0] cap_lo, cap_hi;

`ifdef CHFA_DLC_CLAMP_EN
  function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  function automatic logic [31:0] mask_bytes(input logic [31:0] word,
                                             input logic [3:0]  dlc,
                                             input logic [3:0]  first_byte);
    logic [31:0] res;
    res = '0;
    for (int b = 0; b < 4; b++) begin
      if ((first_byte + 4'(b)) < dlc) res[8*b +: 8] = word[8*b +: 8];
    end
    return res;
  endfunction
`endif

  chfa_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .resetN(resetN),
    .clr   (state == ST_CLEAR),
    .en    (state == ST_WAIT_FILL),
    .tc    (to_tc)
  );

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

  // Field values written at capture; dlc is captured before the data words,
  // so the stored (possibly clamped) dlc masks the data bytes.
  always_comb begin
`ifdef CHFA_DLC_CLAMP_EN
    cap_dlc = clamp_dlc(requestData[CHFA_DLC_MSB:0]);
    cap_lo  = mask_bytes(requestData, frameDlc, 4'd0);
    cap_hi  = mask_bytes(requestData, frameDlc, 4'd4);
`else
    cap_dlc = requestData[CHFA_DLC_MSB:0];
    cap_lo  = requestData;
    cap_hi  = requestData;
`endif
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = (numFrames == '0) ? ST_DONE : ST_CLEAR;
      end
      ST_CLEAR:     state_next = ST_WAIT_FILL;
      ST_WAIT_FILL: begin
        if (dataValid)  state_next = ST_CAPTURE;
        else if (to_tc) state_next = ST_ERROR;
      end
      ST_CAPTURE:   state_next = ST_ADVANCE;
      ST_ADVANCE:   state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST)
          state_next = (word_idx == LAST_WORD) ? ST_PRESENT : ST_CAPTURE;
      end
      ST_PRESENT: begin
        if (frameReady)
          state_next = ((frame_cnt + 14'd1) == num_frames_q) ? ST_DONE : ST_CAPTURE;
      end
      default:      state_next = ST_IDLE;
    endcase

    clear_next = (state_next != ST_CLEAR);
    adv_next   = (state_next == ST_ADVANCE);
    valid_next = (state_next == ST_PRESENT);
    busy_next  = state_next inside {ST_CLEAR, ST_WAIT_FILL, ST_CAPTURE,
                                    ST_ADVANCE, ST_SETTLE, ST_PRESENT};
    done_next  = (state_next == ST_DONE);
    error_next = (state_next == ST_ERROR);
  end

  // State register, registered outputs and job/frame bookkeeping.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= ST_IDLE;
      clear         <= 1'b1;
      advanceBuffer <= 1'b0;
      frameValid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      requestAddr   <= '0;
      numReads      <= '0;
      num_frames_q  <= '0;
      frame_cnt     <= '0;
      word_idx      <= '0;
      settle_cnt    <= '0;
      frameId       <= '0;
      frameIde      <= 1'b0;
      frameRtr      <= 1'b0;
      frameDlc      <= '0;
      frameData     <= '0;
    end else begin
      state         <= state_next;
      clear         <= clear_next;
      advanceBuffer <= adv_next;
      frameValid    <= valid_next;
      busy          <= busy_next;
      done          <= done_next;
      error         <= error_next;

      if (accept && (numFrames != '0)) begin
        requestAddr  <= baseAddr;
        numReads     <= {numFrames, 2'b00};
        num_frames_q <= numFrames;
        frame_cnt    <= '0;
        word_idx     <= '0;
      end

      if (state == ST_ADVANCE)     settle_cnt <= '0;
      else if (state == ST_SETTLE) settle_cnt <= settle_cnt + 8'd1;

      // Index wraps from the last word back to 0 for the next frame.
      if ((state == ST_SETTLE) && (state_next != ST_SETTLE)) word_idx <= word_idx + 2'd1;

      if ((state == ST_PRESENT) && frameReady) frame_cnt <= frame_cnt + 14'd1;

      if (state == ST_CAPTURE) begin
        unique case (word_idx)
          2'd0: begin
            frameId  <= requestData[CHFA_ID_MSB:0];
            frameIde <= requestData[CHFA_IDE_BIT];
            frameRtr <= requestData[CHFA_RTR_BIT];
          end
          2'd1:    frameDlc         <= cap_dlc;
          2'd2:    frameData[31:0]  <= cap_lo;
          default: frameData[63:32] <= cap_hi;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_frame_assembler.sv
// Self-checking bench for can_frame_assembler: a word-buffer controller model
// feeds random jobs, and a frame-level reference model predicts descriptors.
module tb_can_frame_assembler;

  localparam int TO_CYC = 100;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [15:0] baseAddr;
  logic [13:0] numFrames;
  logic [15:0] requestAddr, numReads;
  logic        clear, advanceBuffer;
  logic [31:0] requestData;
  logic        dataValid;
  logic [28:0] frameId;
  logic        frameIde, frameRtr;
  logic [3:0]  frameDlc;
  logic [63:0] frameData;
  logic        frameValid;
  logic        frameReady = 1'b0;
  logic        busy, done, error;

  can_frame_assembler #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .resetN(resetN), .start(start), .baseAddr(baseAddr),
    .numFrames(numFrames), .requestAddr(requestAddr), .numReads(numReads),
    .clear(clear), .advanceBuffer(advanceBuffer), .requestData(requestData),
    .dataValid(dataValid), .frameId(frameId), .frameIde(frameIde),
    .frameRtr(frameRtr), .frameDlc(frameDlc), .frameData(frameData),
    .frameValid(frameValid), .frameReady(frameReady), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Word-buffer controller model.
  logic [31:0] ctrl_words [0:63];
  logic [5:0]  ptr;
  logic        dv;
  logic        adv_prev;
  int          fill_cnt;
  int          fill_delay = 0;
  bit          nodv = 1'b0;
  int          adv_rises = 0;

  assign requestData = ctrl_words[ptr];
  assign dataValid   = dv;

  always @(posedge clk) begin
    if (!resetN) begin
      dv <= 1'b0; ptr <= '0; adv_prev <= 1'b0; fill_cnt <= 0;
    end else begin
      adv_prev <= advanceBuffer;
      if (advanceBuffer && !adv_prev) begin
        ptr <= ptr + 6'd1;
        adv_rises <= adv_rises + 1;
      end
      if (!clear) begin
        ptr <= '0; dv <= 1'b0; fill_cnt <= fill_delay;
      end else if (!nodv) begin
        if (fill_cnt != 0) fill_cnt <= fill_cnt - 1;
        else dv <= 1'b1;
      end
    end
  end

  // Reference model state.
  logic [98:0] exp_frames [0:15];
  int          exp_n = 0;
  int          hs_cnt = 0;
  int          hs_base = 0;
  int          adv_base = 0;
  logic [15:0] m_addr = '0, m_reads = '0;
  int          rmode = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [98:0] pack(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
    logic [3:0]  dlc;
    logic [63:0] d;
    dlc = w1[3:0];
    d   = {w3, w2};
`ifdef CHFA_DLC_CLAMP_EN
    if (dlc > 4'd8) dlc = 4'd8;
    for (int k = 0; k < 8; k++) if (k >= int'(dlc)) d[8*k +: 8] = 8'h00;
`endif
    return {w0[28:0], w0[29], w0[30], dlc, d};
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic compare_loop();
    int idx;
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (frameValid === 1'b1) begin
        idx = hs_cnt - hs_base;
        if (idx >= exp_n) chk("extra_frame", 160'(idx), 160'(exp_n - 1));
        else chk("frame_desc", 160'({frameId, frameIde, frameRtr, frameDlc, frameData}),
                 160'(exp_frames[idx]));
      end
      if (busy === 1'b1)
        chk("req_hold", 160'({requestAddr, numReads}), 160'({m_addr, m_reads}));
      case (rmode)
        0: frameReady = 1'b1;
        1: begin
          if (frameValid === 1'b1 && stall_cnt < 10) begin
            frameReady = 1'b0; stall_cnt++;
          end else frameReady = (frameValid === 1'b1);
        end
        default: frameReady = ($urandom_range(0, 3) != 0);
      endcase
      if (frameValid === 1'b1 && frameReady) begin
        hs_cnt++;
        stall_cnt = 0;
      end
    end
  endtask

  task automatic setup_job(input int n, input logic [15:0] a);
    for (int f = 0; f < n; f++)
      exp_frames[f] = pack(ctrl_words[4*f], ctrl_words[4*f+1], ctrl_words[4*f+2], ctrl_words[4*f+3]);
    exp_n    = n;
    hs_base  = hs_cnt;
    adv_base = adv_rises;
    m_addr   = a;
    m_reads  = 16'(n * 4);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < 4 * n; i++) ctrl_words[i] = $urandom();
  endtask

  task automatic do_start(input logic [15:0] a, input logic [13:0] n);
    @(posedge clk); #1;
    baseAddr = a; numFrames = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_job(input int n);
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1 || error === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("job_done",   160'(done), 160'(1));
    chk("job_error",  160'(error), 160'(0));
    chk("job_busy",   160'(busy), 160'(0));
    chk("job_frames", 160'(hs_cnt - hs_base), 160'(n));
    chk("job_pops",   160'(adv_rises - adv_base), 160'(4 * n));
    chk("job_req",    160'({requestAddr, numReads}), 160'({m_addr, m_reads}));
  endtask

  task automatic check_reset_vals(input string nm);
    chk(nm, 160'({requestAddr, numReads, clear, advanceBuffer, frameId, frameIde, frameRtr,
                  frameDlc, frameData, frameValid, busy, done, error}),
        160'({32'h0, 1'b1, 104'h0}));
  endtask

  initial begin
    int fv_k, done_k, n;
    logic [15:0] a;
    resetN = 1'b0; start = 1'b0; baseAddr = '0; numFrames = '0;
    fork compare_loop(); join_none
    @(posedge clk); #1;
    check_reset_vals("reset_values");
    @(posedge clk); #1;
    resetN = 1'b1;

    // Zero-frame job finishes at once without touching clear.
    do_start(16'h0000, 14'd0);
    chk("zero_done", 160'(done), 160'(1));
    chk("zero_clear", 160'(clear), 160'(1));
    chk("zero_busy", 160'(busy), 160'(0));
    @(posedge clk); #1;
    chk("zero_clear_next", 160'(clear), 160'(1));

    // Single known frame, ready tied high.
    rmode = 0; fill_delay = 0;
    ctrl_words[0] = 32'h20000123; ctrl_words[1] = 32'h00000008;
    ctrl_words[2] = 32'h44332211; ctrl_words[3] = 32'h88776655;
    setup_job(1, 16'h0010);
    do_start(16'h0010, 14'd1);
    chk("t1_clear_low", 160'(clear), 160'(0));
    fv_k = 0; done_k = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (frameValid === 1'b1 && fv_k == 0) begin
        fv_k = k;
        chk("t1_id",   160'(frameId), 160'(29'h123));
        chk("t1_ide",  160'(frameIde), 160'(1));
        chk("t1_rtr",  160'(frameRtr), 160'(0));
        chk("t1_dlc",  160'(frameDlc), 160'(8));
        chk("t1_data", 160'(frameData), 160'(64'h8877665544332211));
      end
      if (done === 1'b1) begin done_k = k; break; end
    end
    chk("t1_fv_latency", 160'(fv_k), 160'(23));
    chk("t1_done_latency", 160'(done_k), 160'(24));
    chk("t1_numreads", 160'(numReads), 160'(4));
    chk("t1_addr", 160'(requestAddr), 160'(16'h0010));
    finish_job(1);

    // Three frames, each stalled 10 cycles; a start mid-job must be ignored.
    rmode = 1; fill_delay = 4;
    rand_words(3);
    setup_job(3, 16'h1234);
    do_start(16'h1234, 14'd3);
    for (int k = 0; k < 500; k++) begin
      if (hs_cnt - hs_base >= 1) break;
      @(posedge clk); #1;
    end
    baseAddr = 16'hFFFF; numFrames = 14'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_job(3);

    // dlc 15 in w1.
    rmode = 0; fill_delay = 1;
    ctrl_words[0] = 32'h00000456; ctrl_words[1] = 32'h0000000F;
    ctrl_words[2] = 32'hDDCCBBAA; ctrl_words[3] = 32'h11223344;
    setup_job(1, 16'h0200);
    do_start(16'h0200, 14'd1);
    for (int k = 0; k < 100; k++) begin
      if (frameValid === 1'b1) break;
      @(posedge clk); #1;
    end
`ifdef CHFA_DLC_CLAMP_EN
    chk("dlc15_dlc", 160'(frameDlc), 160'(8));
`else
    chk("dlc15_dlc", 160'(frameDlc), 160'(15));
`endif
    chk("dlc15_data", 160'(frameData), 160'(64'h11223344DDCCBBAA));
    finish_job(1);

    // Fill never completes: error after TO_CYC cycles in WAIT_FILL.
    nodv = 1'b1;
    setup_job(2, 16'h0300);
    do_start(16'h0300, 14'd2);
    for (int k = 1; k <= TO_CYC + 1; k++) begin
      @(posedge clk); #1;
      if (k == TO_CYC)     chk("to_not_yet", 160'(error), 160'(0));
      if (k == TO_CYC + 1) chk("to_error", 160'(error), 160'(1));
    end
    chk("to_busy", 160'(busy), 160'(0));
    chk("to_done", 160'(done), 160'(0));
    chk("to_no_pops", 160'(adv_rises - adv_base), 160'(0));
    nodv = 1'b0;

    // Reset during the second word of frame 2, then a clean job.
    rmode = 0; fill_delay = 2;
    rand_words(3);
    setup_job(3, 16'h0400);
    do_start(16'h0400, 14'd3);
    for (int k = 0; k < 300; k++) begin
      if (adv_rises - adv_base >= 5) break;
      @(posedge clk); #1;
    end
    resetN = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midjob_reset");
    chk("midjob_frames", 160'(hs_cnt - hs_base), 160'(1));
    resetN = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", 160'({frameValid, busy, done, error, clear}), 160'(5'b00001));
    rand_words(2);
    setup_job(2, 16'h0500);
    do_start(16'h0500, 14'd2);
    finish_job(2);

    // Random jobs.
    for (int j = 0; j < 5; j++) begin
      n = $urandom_range(1, 5);
      a = 16'($urandom());
      rmode = $urandom_range(0, 2);
      fill_delay = $urandom_range(0, 20);
      rand_words(n);
      setup_job(n, a);
      do_start(a, 14'(n));
      finish_job(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
